// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display scanner: controller states, digit count and
// seven-segment codes/patterns.
package clock_disp_pkg;

  localparam int unsigned DIGITS = 6;

  typedef logic [2:0] state_t;
  localparam state_t StIdle   = 3'd0;
  localparam state_t StCheck  = 3'd1;
  localparam state_t StConvH  = 3'd2;
  localparam state_t StConvM  = 3'd3;
  localparam state_t StConvS  = 3'd4;
  localparam state_t StCommit = 3'd5;

  // Digit codes: 0..9 are decimal, plus two special glyphs
  typedef logic [3:0] code_t;
  localparam code_t CodeDash  = 4'hA;
  localparam code_t CodeBlank = 4'hF;

  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegDash  = 7'h40;
  localparam logic [6:0] SegBlank = 7'h00;

endpackage

// File: rtl/clock_disp_scan_seg7_enc.sv
// Combinational digit-code to seven-segment pattern (bit0 = a .. bit6 = g, active-high).
module seg7_enc
  import clock_disp_pkg::*;
(
  input  code_t      code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    case (code)
      4'd0:     seg = Seg0;
      4'd1:     seg = Seg1;
      4'd2:     seg = Seg2;
      4'd3:     seg = Seg3;
      4'd4:     seg = Seg4;
      4'd5:     seg = Seg5;
      4'd6:     seg = Seg6;
      4'd7:     seg = Seg7;
      4'd8:     seg = Seg8;
      4'd9:     seg = Seg9;
      CodeDash: seg = SegDash;
      default:  seg = SegBlank;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Accepts a binary hh:mm:ss, converts it to BCD by repeated subtraction, commits it atomically
// to six display registers and multiplexes those onto a scanned seven-segment display.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_HT = 1'b0
) (
  input  logic       ap_clk,
  input  logic       ap_rst,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       time_vld,
  output logic       time_rdy,
  output logic [6:0] seg,
  output logic [5:0] dig_sel,
  output logic       dp,
  output logic       err_o
);

  state_t state_q, state_d;
  logic [7:0] hh_q, mm_q, ss_q, rem_q;
  logic [3:0] tens_q;
  logic       err_pend_q, err_q;
  logic [2:0] fld;
  logic       range_bad;
  // Working digits fill up during conversion; disp_q only changes on COMMIT
  logic [DIGITS-1:0][3:0] work_q, disp_q;

  logic [15:0] presc_q;
  logic [2:0]  idx_q;
  code_t       cur_code;
  logic [6:0]  enc_seg, seg_q;
  logic [5:0]  dig_sel_q;
  logic        dp_q;

  assign range_bad = (hh_q > 8'd23) || (mm_q > 8'd59) || (ss_q > 8'd59);
  assign time_rdy  = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (time_vld) state_d = StCheck;
      StCheck:  state_d = range_bad ? StCommit : StConvH;
      StConvH:  if (rem_q < 8'd10) state_d = StConvM;
      StConvM:  if (rem_q < 8'd10) state_d = StConvS;
      StConvS:  if (rem_q < 8'd10) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    fld = 3'd0;
    case (state_q)
      StConvM: fld = 3'd2;
      StConvS: fld = 3'd4;
      default: fld = 3'd0;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= StIdle;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      rem_q      <= '0;
      tens_q     <= '0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
      work_q     <= '0;
      disp_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (time_vld) begin
            hh_q <= hh;
            mm_q <= mm;
            ss_q <= ss;
          end
        end
        StCheck: begin
          err_pend_q <= range_bad;
          rem_q      <= hh_q;
          tens_q     <= '0;
        end
        StConvH, StConvM, StConvS: begin
          if (rem_q >= 8'd10) begin
            rem_q  <= rem_q - 8'd10;
            tens_q <= tens_q + 4'd1;
          end else begin
            work_q[fld]        <= tens_q;
            work_q[fld + 3'd1] <= rem_q[3:0];
            rem_q              <= (state_q == StConvH) ? mm_q : ss_q;
            tens_q             <= '0;
          end
        end
        StCommit: begin
          disp_q <= err_pend_q ? {DIGITS{CodeDash}} : work_q;
          err_q  <= err_pend_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == 16'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  always_comb begin
    cur_code = disp_q[idx_q];
    if (BLANK_HT && (idx_q == 3'd0) && (cur_code == 4'd0)) cur_code = CodeBlank;
  end

  seg7_enc u_enc (
    .code (cur_code),
    .seg  (enc_seg)
  );

  // Outputs follow idx_q/disp_q one edge later, so a commit and a scan step never tear
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      seg_q     <= BLANK_HT ? SegBlank : Seg0;
      dig_sel_q <= 6'b000001;
      dp_q      <= 1'b0;
    end else begin
      seg_q     <= enc_seg;
      dig_sel_q <= 6'b000001 << idx_q;
      dp_q      <= ((idx_q == 3'd1) || (idx_q == 3'd3)) && !disp_q[5][0] && !err_q;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;
  assign dp      = dp_q;
  assign err_o   = err_q;

endmodule

// File: doc/clock_disp_scan.md
CLOCK_DISP_SCAN -- requirements
Module: clock_disp_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each digit is held before the scan advances (legal range 2..65535).
REQ-002 Parameter BLANK_HT, default 0, when 1 a hour-tens digit of 0 is blanked.
REQ-003 ap_clk  in  1  single clock; all state changes occur on its rising edge.
REQ-004 ap_rst  in  1  reset, asynchronous, active-high.
REQ-005 hh, mm, ss  in  8 each  binary time from the Clock block (legal: hh 0..23, mm 0..59, ss 0..59).
REQ-006 time_vld  in  1  new time present on hh/mm/ss.
REQ-007 time_rdy  out  1  block accepts a time this cycle.
REQ-008 seg  out  7  segment drive, active-high, bit0=a .. bit6=g, registered.
REQ-009 dig_sel  out  6  one-hot digit enable, bit0 = leftmost (hour tens), registered.
REQ-010 dp  out  1  colon dot, registered.
REQ-011 err_o  out  1  last accepted time was out of range, registered.

Function
REQ-012 Transfer occurs on a rising edge with time_vld=1 and time_rdy=1; hh/mm/ss are captured that edge.
REQ-013 time_rdy = 1 only in state IDLE; time_vld while not ready is ignored, not queued.
REQ-014 States IDLE, CHECK, CONV_H, CONV_M, CONV_S, COMMIT; transfer: IDLE->CHECK.
REQ-015 CHECK: any field out of range -> COMMIT with error flag; else -> CONV_H.
REQ-016 CONV_x: if remainder >= 10, subtract 10 and increment tens (one step per cycle); else store tens/ones, go to next field (H->M->S->COMMIT).
REQ-017 Latency transfer-to-COMMIT-edge = 1 + (hT+1) + (mT+1) + (sT+1) + 1 cycles; 23:59:59 = 17; error path = 2.
REQ-018 COMMIT updates all six display digit registers and err_o atomically in one edge, then -> IDLE.
REQ-019 Error commit: err_o=1, all six digits show dash (7'h40), dp=0; next valid commit clears err_o.
REQ-020 Encoding: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F dash=40 blank=00 (hex).
REQ-021 Prescaler counts 0..SCAN_DIV-1 continuously; on wrap digit index advances 0..5, 5 wraps to 0.
REQ-022 seg/dig_sel/dp reflect current digit index and display registers one cycle later (registered); commit and scan advance on the same edge are both honoured.
REQ-023 dp = 1 on digits 1 and 3 when displayed seconds-ones is even and err_o=0; else 0.
REQ-024 Scan runs independently of conversion; display never shows a partially converted time.

Reset
REQ-025 ap_rst asserted: state IDLE, all display digits 0, err_o=0, prescaler 0, digit index 0, seg=7'h3F (7'h00 if BLANK_HT=1), dig_sel=6'b000001, dp=0, time_rdy=1.
REQ-026 Reset during CHECK/CONV_x/COMMIT aborts conversion; display registers take reset values, no partial commit.

Structure
REQ-027 Package clock_disp_pkg holds the state enum, DIGITS=6, and segment encoding constants (0-9, dash, blank).
REQ-028 One sub-module seg7_enc: combinational 4-bit code (0-9, dash, blank) to 7-bit segment pattern.

Verification
REQ-029 Reset pulse -> seg=7'h3F, dig_sel=6'b000001, time_rdy=1, err_o=0.
REQ-030 hh=23 mm=59 ss=59 with time_vld -> time_rdy low 17 cycles; digits 2,3,5,9,5,9; digit0 seg=7'h5B, digit5 seg=7'h6F; dp=0 (59 odd).
REQ-031 hh=24 mm=0 ss=0 -> err_o=1 after 2 cycles, every digit seg=7'h40, dp=0; then 12:34:56 -> err_o=0, digits 1,2,3,4,5,6, dp=1 on digits 1 and 3.
REQ-032 SCAN_DIV=4 -> dig_sel changes every 4 cycles, 6'b100000 followed by 6'b000001.
REQ-033 ap_rst pulsed in CONV_M after prior commit of 10:10:10 -> all digits 0, state IDLE, time_rdy=1 next cycle.
REQ-034 time_vld held with changing values during conversion -> only the first value committed; next transfer on first IDLE cycle.
